// File: rtl/alu_pkg.sv
// Shared opcode encoding and helpers for the multi-cycle ALU.
// Opcodes 0xC..0xF are undefined and reported as illegal.
package alu_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_NOT  = 4'h5,
        OP_SHL  = 4'h6,
        OP_SHR  = 4'h7,
        OP_SAR  = 4'h8,
        OP_MUL  = 4'h9,
        OP_DIVU = 4'hA,
        OP_REMU = 4'hB
    } alu_op_t;

    function automatic logic is_multicycle(input logic [OP_W-1:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// MUL: hi:lo ends as the 2*WIDTH product. DIVU/REMU: lo ends as quotient, hi as remainder.
module alu_iter_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    cnt;
    logic             div_mode;
    logic [WIDTH-1:0] hi, lo, opnd;
    logic [WIDTH-1:0] hi_next, lo_next;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_part;
    logic [WIDTH:0]   div_diff;

    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        div_part = {hi, lo[WIDTH-1]};
        div_diff = div_part - {1'b0, opnd};
        hi_next  = hi;
        lo_next  = lo;
        if (div_mode) begin
            // hi stays below opnd, so the partial remainder always fits back into WIDTH bits
            if (div_part >= {1'b0, opnd}) begin
                hi_next = div_diff[WIDTH-1:0];
                lo_next = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_next = div_part[WIDTH-1:0];
                lo_next = {lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_next = mul_sum[WIDTH:1];
            lo_next = {mul_sum[0], lo[WIDTH-1:1]};
        end
    end

    // Final-step values are presented directly so the caller can register them on the done cycle.
    assign done   = (cnt == CW'(1));
    assign res_hi = hi_next;
    assign res_lo = lo_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt      <= '0;
            div_mode <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            opnd     <= '0;
        end else if (start) begin
            cnt      <= CW'(WIDTH);
            div_mode <= is_div;
            hi       <= '0;
            lo       <= is_div ? a : b;
            opnd     <= is_div ? b : a;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
            hi  <= hi_next;
            lo  <= lo_next;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready request and response ports.
//   state  | meaning
//   S_IDLE | ready for a request; single-cycle ops complete on acceptance
//   S_EXEC | iterative MUL/DIVU/REMU in progress
//   S_DONE | response valid, held until out_ready
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             div_zero,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t           state, state_n;
    logic [OP_W-1:0]  op_q;
    logic             go_multi, start;
    logic [WIDTH:0]   sum_ext, diff_ext;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] sc_res;
    logic             sc_carry, sc_ovf, sc_dz, sc_ill;
    logic             md_done;
    logic [WIDTH-1:0] md_hi, md_lo, md_res;
    logic             md_carry;

    assign go_multi = is_multicycle(in_op) && (in_b != '0);
    assign sum_ext  = {1'b0, in_a} + {1'b0, in_b};
    assign diff_ext = {1'b0, in_a} - {1'b0, in_b};
    assign sh       = in_b[SHW-1:0];

    // Zero-divisor DIVU/REMU and MUL by zero resolve here without entering EXEC.
    always_comb begin
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        sc_dz    = 1'b0;
        sc_ill   = 1'b0;
        case (in_op)
            OP_ADD: begin
                sc_res   = sum_ext[WIDTH-1:0];
                sc_carry = sum_ext[WIDTH];
                sc_ovf   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum_ext[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res   = diff_ext[WIDTH-1:0];
                sc_carry = diff_ext[WIDTH];
                sc_ovf   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff_ext[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_AND:  sc_res = in_a & in_b;
            OP_OR:   sc_res = in_a | in_b;
            OP_XOR:  sc_res = in_a ^ in_b;
            OP_NOT:  sc_res = ~in_a;
            OP_SHL:  sc_res = in_a << sh;
            OP_SHR:  sc_res = in_a >> sh;
            OP_SAR:  sc_res = WIDTH'($signed(in_a) >>> sh);
            OP_MUL:  sc_res = '0;
            OP_DIVU: begin
                sc_res = '1;
                sc_dz  = 1'b1;
            end
            OP_REMU: begin
                sc_res = in_a;
                sc_dz  = 1'b1;
            end
            default: sc_ill = 1'b1;
        endcase
    end

    alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .is_div (in_op != OP_MUL),
        .a      (in_a),
        .b      (in_b),
        .done   (md_done),
        .res_hi (md_hi),
        .res_lo (md_lo)
    );

    assign md_res   = (op_q == OP_REMU) ? md_hi : md_lo;
    assign md_carry = (op_q == OP_MUL) && (md_hi != '0);

    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        start    = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    start   = go_multi;
                    state_n = go_multi ? S_EXEC : S_DONE;
                end
            end
            S_EXEC: if (md_done) state_n = S_DONE;
            S_DONE: if (out_ready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign out_valid = (state == S_DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            op_q     <= '0;
            result   <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            div_zero <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            state <= state_n;
            if (state == S_IDLE && in_valid) begin
                op_q <= in_op;
                if (!go_multi) begin
                    result   <= sc_res;
                    zero     <= (sc_res == '0);
                    carry    <= sc_carry;
                    overflow <= sc_ovf;
                    div_zero <= sc_dz;
                    illegal  <= sc_ill;
                end
            end
            if (state == S_EXEC && md_done) begin
                result   <= md_res;
                zero     <= (md_res == '0);
                carry    <= md_carry;
                overflow <= 1'b0;
                div_zero <= 1'b0;
                illegal  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc at WIDTH=32: results, flags, latency, backpressure, reset abort.
module tb_alu_mc;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero, carry, overflow, div_zero, illegal;

    int n_vec = 0;
    int n_err = 0;

    alu_mc #(.WIDTH(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow),
        .div_zero  (div_zero),
        .illegal   (illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // flags packed as {zero, carry, overflow, div_zero, illegal}
    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [4:0]  flg;
        int          lat;
    } vec_t;

    vec_t vecs[$] = '{
        '{4'h0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 5'b00100, 1},
        '{4'h1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 5'b01000, 1},
        '{4'h8, 32'h8000_0000, 32'h0000_0023, 32'hF000_0000, 5'b00000, 1},
        '{4'h9, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 5'b11000, 33},
        '{4'hA, 32'd100,       32'd7,         32'd14,        5'b00000, 33},
        '{4'hB, 32'd100,       32'd7,         32'd2,         5'b00000, 33},
        '{4'hA, 32'd5,         32'd0,         32'hFFFF_FFFF, 5'b00010, 1},
        '{4'hF, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 5'b10001, 1},
        '{4'h0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 5'b11000, 1},
        '{4'h1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 5'b00100, 1},
        '{4'h2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 5'b00000, 1},
        '{4'h3, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 5'b00000, 1},
        '{4'h4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'b00000, 1},
        '{4'h5, 32'h1234_5678, 32'h0000_0000, 32'hEDCB_A987, 5'b00000, 1},
        '{4'h6, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 5'b00000, 1},
        '{4'h7, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 5'b00000, 1},
        '{4'h8, 32'h7FFF_FFFF, 32'h0000_001F, 32'h0000_0000, 5'b10000, 1},
        '{4'h9, 32'h0001_2345, 32'h0000_03E8, 32'h0471_C588, 5'b00000, 33},
        '{4'h9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 5'b01000, 33},
        '{4'hB, 32'd5,         32'd0,         32'd5,         5'b00010, 1},
        '{4'h9, 32'd5,         32'd0,         32'd0,         5'b10000, 1},
        '{4'hA, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 5'b00000, 33}
    };

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        @(negedge clock);
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_a     = 32'hDEAD_BEEF;
        in_b     = 32'hDEAD_BEEF;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!out_valid && lat < 100);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int  lat;
        bit  stale;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {27'b0, zero, carry, overflow, div_zero, illegal}, 32'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_res", i), result, vecs[i].res);
            chk($sformatf("v%0d_flg", i), {27'b0, zero, carry, overflow, div_zero, illegal},
                {27'b0, vecs[i].flg});
            drain();
        end

        // backpressure: response held, new requests ignored
        run_op(4'h0, 32'd3, 32'd4, lat);
        chk("bp_lat", lat, 32'd1);
        in_op    = 4'h1;
        in_a     = 32'd100;
        in_b     = 32'd1;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk($sformatf("bp%0d_valid", k), {31'b0, out_valid}, 32'd1);
            chk($sformatf("bp%0d_ready", k), {31'b0, in_ready}, 32'd0);
            chk($sformatf("bp%0d_res", k), result, 32'd7);
            chk($sformatf("bp%0d_flg", k), {27'b0, zero, carry, overflow, div_zero, illegal}, 32'd0);
        end
        in_valid = 1'b0;
        drain();
        @(negedge clock);
        chk("bp_post_ready", {31'b0, in_ready}, 32'd1);
        chk("bp_post_valid", {31'b0, out_valid}, 32'd0);

        // reset during MUL discards the operation
        @(negedge clock);
        in_op    = 4'h9;
        in_a     = 32'd3;
        in_b     = 32'd5;
        in_valid = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("mrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mrst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("mrst_result", result, 32'd0);
        stale = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (out_valid) stale = 1'b1;
        end
        chk("mrst_no_stale", {31'b0, stale}, 32'd0);

        run_op(4'hA, 32'd100, 32'd7, lat);
        chk("mrst_after_lat", lat, 32'd33);
        chk("mrst_after_res", result, 32'd14);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
